// File: rtl/rng_draw_gen.sv
// Fibonacci LFSR random source with seed loading and a req/ready/valid draw handshake.
// Define RNG_RANGE_EN to enable rejection sampling of draws against MAX_VAL.
module rng_draw_gen #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [63:0] TAPS     = 64'h8020_0003,
    parameter logic [63:0] SEED     = 64'h1,
    parameter int unsigned OUT_BITS = 4,
    parameter int unsigned MAX_VAL  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic                req,
    output logic                ready,
    output logic                valid,
    output logic [OUT_BITS-1:0] rnd_out
);

    localparam int unsigned      CNT_W    = $clog2(OUT_BITS + 1);
    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_VAL = SEED[WIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK,
        DONE
    } fsm_t;

    fsm_t                fsm;
    logic [WIDTH-1:0]    state;
    logic [OUT_BITS-1:0] acc;
    logic [CNT_W-1:0]    cnt;
    logic                feedback;
    logic                accept;
    logic [WIDTH-1:0]    seed_safe;

    assign feedback  = ^(state & TAP_MASK);
    // An all-zero seed would freeze the LFSR forever.
    assign seed_safe = (seed_in == '0) ? WIDTH'(1) : seed_in;

`ifdef RNG_RANGE_EN
    assign accept = ({1'b0, acc} < (OUT_BITS + 1)'(MAX_VAL));
`else
    logic unused_max_val;
    assign unused_max_val = |MAX_VAL;
    assign accept         = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SEED_VAL;
            fsm     <= IDLE;
            ready   <= 1'b1;
            valid   <= 1'b0;
            rnd_out <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else if (seed_load) begin
            // Loading a seed abandons any draw in flight; rnd_out keeps its last value.
            state <= seed_safe;
            fsm   <= IDLE;
            ready <= 1'b1;
            valid <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= {state[WIDTH-2:0], feedback};
            unique case (fsm)
                IDLE: begin
                    if (req) begin
                        fsm   <= COLLECT;
                        ready <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                COLLECT: begin
                    acc <= (acc << 1) | OUT_BITS'(state[WIDTH-1]);
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(OUT_BITS - 1)) begin
                        fsm <= CHECK;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        rnd_out <= acc;
                        valid   <= 1'b1;
                        fsm     <= DONE;
                    end else begin
                        fsm <= COLLECT;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    fsm   <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_draw_gen.sv
// Directed bench for rng_draw_gen: reset, draw timing/values, seed handling, abort, LFSR period.
// With RNG_RANGE_EN defined, also exercises rejection sampling against MAX_VAL=6.
module tb_rng_draw_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        seed_load = 1'b0;
    logic [31:0] seed_in = '0;
    logic        req = 1'b0;
    logic        ready;
    logic        valid;
    logic [3:0]  rnd_out;

    logic        s_ready;
    logic        s_valid;
    logic [3:0]  s_rnd_out;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    int unsigned lat;
    logic [3:0]  rnd;
    logic [3:0]  prev_rnd;
    int unsigned hits;
    int unsigned period;

    always #5 clk = ~clk;

    rng_draw_gen #(
        .WIDTH(32), .TAPS(64'h8020_0003), .SEED(64'h1), .OUT_BITS(4), .MAX_VAL(6)
    ) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .ready(ready), .valid(valid), .rnd_out(rnd_out)
    );

    rng_draw_gen #(
        .WIDTH(8), .TAPS(64'hB8), .SEED(64'h1), .OUT_BITS(4), .MAX_VAL(10)
    ) u_small (
        .clk(clk), .rst(rst), .seed_load(1'b0), .seed_in(8'h00),
        .req(1'b0), .ready(s_ready), .valid(s_valid), .rnd_out(s_rnd_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call at a negedge where req was just raised; returns at the negedge after the valid cycle.
    task automatic run_draw(input string tag, output int unsigned lat_o, output logic [3:0] rnd_o);
        int unsigned busy_ready;
        busy_ready = 0;
        @(negedge clk);
        req = 1'b0;
        lat_o = 1;
        check({tag, "_ready_drop"}, 64'(ready), 64'(0));
        while (!valid && lat_o < 400) begin
            if (ready) busy_ready++;
            @(negedge clk);
            lat_o++;
        end
        check({tag, "_valid_seen"}, 64'(valid), 64'(1));
        check({tag, "_busy_ready"}, 64'(busy_ready + 32'(ready)), 64'(0));
        rnd_o = rnd_out;
        @(negedge clk);
        check({tag, "_valid_pulse"}, 64'(valid), 64'(0));
        check({tag, "_ready_back"}, 64'(ready), 64'(1));
    endtask

    // With width 32, a draw right after loading S returns S[30:27].
    task automatic seeded_draw(input string tag, input logic [31:0] s, input logic [3:0] exp);
        int unsigned l;
        logic [3:0]  r;
        @(negedge clk);
        seed_in   = s;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        req       = 1'b1;
        run_draw(tag, l, r);
        check({tag, "_latency"}, 64'(l), 64'(6));
        check({tag, "_rnd"}, 64'(r), 64'(exp));
    endtask

    initial begin
        // Reset values, then a request in the very first active cycle.
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_rnd", 64'(rnd_out), 64'(0));
        check("rst_state", 64'(dut.state), 64'h1);
        rst = 1'b1;
        req = 1'b1;
        run_draw("first", lat, rnd);
        check("first_latency", 64'(lat), 64'(6));
        check("first_rnd", 64'(rnd), 64'(0));

        seeded_draw("seedA0", 32'hA000_0000, 4'h4);
        seeded_draw("seed18", 32'h1800_0000, 4'h3);
`ifndef RNG_RANGE_EN
        seeded_draw("seedFF", 32'hFFFF_FFFF, 4'hF);
        seeded_draw("seed50", 32'h5000_0000, 4'hA);
        seeded_draw("seed38", 32'h3800_0000, 4'h7);
`endif

        // Zero seed must be replaced by 1 and never lock up.
        @(negedge clk);
        seed_in   = '0;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("zero_seed_state", 64'(dut.state), 64'h1);
        hits = 0;
        repeat (100) begin
            @(negedge clk);
            if (dut.state == '0) hits++;
        end
        check("zero_seed_lockup", 64'(hits), 64'(0));

        // Abort a draw after two captures with seed_load.
        seeded_draw("pre_abort", 32'hA000_0000, 4'h4);
        prev_rnd = rnd_out;
        @(negedge clk);
        seed_in   = 32'hFFFF_FFFF;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        req       = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        seed_in   = 32'h1234_5678;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("abort_ready", 64'(ready), 64'(1));
        check("abort_valid", 64'(valid), 64'(0));
        check("abort_rnd_held", 64'(rnd_out), 64'(prev_rnd));
        check("abort_state", 64'(dut.state), 64'h1234_5678);
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid || !ready) hits++;
        end
        check("abort_quiet", 64'(hits), 64'(0));
        seeded_draw("post_abort", 32'h1800_0000, 4'h3);

`ifdef RNG_RANGE_EN
        // First attempt collects 4'hF and must be rejected before a value below 6 emerges.
        @(negedge clk);
        seed_in   = 32'hFFFF_FFFF;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        req       = 1'b1;
        run_draw("range_first", lat, rnd);
        check("range_first_lt6", 64'(rnd < 4'd6), 64'(1));
        check("range_first_retry", 64'(lat >= 11 && (lat - 6) % 5 == 0), 64'(1));
        hits = 0;
        for (int i = 0; i < 1000; i++) begin
            req = 1'b1;
            run_draw("range_loop", lat, rnd);
            if (rnd >= 4'd6) hits++;
        end
        check("range_1000_lt6", 64'(hits), 64'(0));
`endif

        // Asynchronous reset in the middle of a draw.
        @(negedge clk);
        seed_in   = 32'hFFFF_FFFF;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        req       = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_ready", 64'(ready), 64'(1));
        check("async_valid", 64'(valid), 64'(0));
        check("async_rnd", 64'(rnd_out), 64'(0));
        check("async_state", 64'(dut.state), 64'h1);

        // 8-bit LFSR with taps B8 must cycle through all 255 nonzero states.
        @(negedge clk);
        rst    = 1'b1;
        period = 0;
        hits   = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (u_small.state == 8'h00) hits++;
            if (u_small.state == 8'h01) begin
                period = n;
                break;
            end
        end
        check("small_period", 64'(period), 64'(255));
        check("small_no_zero", 64'(hits), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
